branch_resolve_ctrl: RTL

Branch resolution and redirect controller for the RV32I 5-stage pipeline. Predicts conditional-branch direction at IF with a 2-bit-counter branch history table. Checks the EX-stage outcome (from the branch decision unit) against that prediction. On a mispredict or jump, raises a held redirect handshake to fetch and flushes IF/ID and ID/EX.

---
 rtl/branch_resolve_ctrl_pkg.sv | 26 ++
 rtl/branch_resolve_ctrl_bht_2bit.sv | 32 +++
 rtl/branch_resolve_ctrl.sv | 106 ++++++++++
 3 files changed

// File: rtl/branch_resolve_ctrl_pkg.sv
// Shared RV32I opcodes, widths and types for the branch resolution controller
// and its branch history table.
package branch_resolve_ctrl_pkg;

    localparam int WORD_LENGTH = 32;
    localparam int OPCODE_SIZE = 7;

    localparam logic [OPCODE_SIZE-1:0] OP_BRANCH = 7'b1100011;
    localparam logic [OPCODE_SIZE-1:0] OP_JAL    = 7'b1101111;
    localparam logic [OPCODE_SIZE-1:0] OP_JALR   = 7'b1100111;

    typedef enum logic {IDLE, REDIRECT} br_state_t;

    typedef logic [1:0] bht_cnt_t;

    localparam bht_cnt_t BHT_INIT = 2'b01;

    // 2-bit saturating counter step toward taken (3) or not-taken (0).
    function automatic bht_cnt_t sat_update(input bht_cnt_t cnt, input logic taken);
        if (taken)
            return (cnt == 2'b11) ? cnt : bht_cnt_t'(cnt + 2'b01);
        else
            return (cnt == 2'b00) ? cnt : bht_cnt_t'(cnt - 2'b01);
    endfunction

endpackage

// File: rtl/branch_resolve_ctrl_bht_2bit.sv
// Branch history table of 2-bit saturating counters: combinational read port,
// single saturating write port, asynchronous reset to weakly not-taken.
module bht_2bit
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int BHT_ENTRIES = 16,
    parameter int IDX_W       = $clog2(BHT_ENTRIES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output bht_cnt_t         rd_cnt,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    bht_cnt_t cnt [BHT_ENTRIES];

    // Read sees the pre-edge value when it hits the entry being written.
    assign rd_cnt = cnt[rd_idx];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++)
                cnt[i] <= BHT_INIT;
        end else if (wr_en) begin
            cnt[wr_idx] <= sat_update(cnt[wr_idx], wr_taken);
        end
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Resolves EX-stage branches/jumps against the fetch-time prediction and
// drives a held redirect handshake plus IF/ID and ID/EX flushes.
module branch_resolve_ctrl
    import branch_resolve_ctrl_pkg::*;
#(
    parameter int BHT_ENTRIES = 16,
    parameter int CNT_W       = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WORD_LENGTH-1:0] if_pc,
    output logic                   pred_taken,
    input  logic                   ex_valid,
    input  logic [OPCODE_SIZE-1:0] ex_opcode,
    input  logic [WORD_LENGTH-1:0] ex_pc,
    input  logic [WORD_LENGTH-1:0] ex_target,
    input  logic                   ex_pred_taken,
    input  logic                   branch_taken,
    input  logic                   stall,
    output logic                   redirect_valid,
    output logic [WORD_LENGTH-1:0] redirect_pc,
    input  logic                   redirect_ready,
    output logic                   flush_if_id,
    output logic                   flush_id_ex,
    output logic [CNT_W-1:0]       branch_count,
    output logic [CNT_W-1:0]       mispredict_count
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    br_state_t              state, state_next;
    logic                   is_br, is_jmp, resolve, taken, mispredict;
    logic [WORD_LENGTH-1:0] target;
    bht_cnt_t               rd_cnt;
    logic                   unused_pc_bits;

    assign unused_pc_bits = ^{if_pc[WORD_LENGTH-1:IDX_W+2], if_pc[1:0]};

    always_comb begin
        is_br      = (ex_opcode == OP_BRANCH);
        is_jmp     = (ex_opcode == OP_JAL) || (ex_opcode == OP_JALR);
        // A stalled EX instruction only resolves on its first unstalled cycle.
        resolve    = (state == IDLE) && ex_valid && !stall && (is_br || is_jmp);
        taken      = is_jmp ? 1'b1 : branch_taken;
        mispredict = is_jmp || (taken != ex_pred_taken);
        target     = taken ? ex_target : ex_pc + WORD_LENGTH'(4);
    end

    bht_2bit #(
        .BHT_ENTRIES (BHT_ENTRIES),
        .IDX_W       (IDX_W)
    ) u_bht (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (if_pc[IDX_W+1:2]),
        .rd_cnt   (rd_cnt),
        .wr_en    (resolve && is_br),
        .wr_idx   (ex_pc[IDX_W+1:2]),
        .wr_taken (taken)
    );

    assign pred_taken = rd_cnt[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next     = state;
        redirect_valid = 1'b0;
        flush_if_id    = 1'b0;
        flush_id_ex    = 1'b0;
        case (state)
            IDLE: begin
                if (resolve && mispredict)
                    state_next = REDIRECT;
            end
            REDIRECT: begin
                redirect_valid = 1'b1;
                flush_if_id    = 1'b1;
                flush_id_ex    = 1'b1;
                if (redirect_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redirect_pc      <= '0;
            branch_count     <= '0;
            mispredict_count <= '0;
        end else if (resolve) begin
            branch_count <= branch_count + CNT_W'(1);
            if (mispredict) begin
                redirect_pc      <= target;
                mispredict_count <= mispredict_count + CNT_W'(1);
            end
        end
    end

endmodule
